// File: rtl/mlu_pkg.sv
// Shared MLU definitions: collector FSM encoding, multiplier state constants, default widths.
package mlu_pkg;

  localparam int MLU_RES_W = 6;

  typedef enum logic [1:0] {
    COLL_IDLE = 2'd0,
    COLL_ARM  = 2'd1,
    COLL_WAIT = 2'd2
  } coll_state_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mlu_sync_fifo.sv
// Synchronous FIFO; the caller only asserts push when a slot is free (or pop frees one).
module mlu_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mlu_result_collector.sv
// Issues multiplier start, captures the result on the ready rising edge, buffers it in a
// FIFO and sums it into a saturating accumulator; a watchdog flags a stalled multiplier.
module mlu_result_collector
  import mlu_pkg::*;
#(
  parameter int RES_W   = MLU_RES_W,
  parameter int DEPTH   = 4,
  parameter int ACC_W   = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       clr,
  output logic                       mlu_start,
  input  logic                       mlu_ready,
  input  logic [RES_W-1:0]           mlu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [ACC_W-1:0]           acc,
  output logic                       overflow,
  output logic                       timeout
);

  localparam int WD_W = $clog2(TIMEOUT);

  coll_state_t     r_state;
  logic            r_start;
  logic            r_rdy_q;
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;
  logic            r_overflow;
  logic [ACC_W-1:0] r_acc;

  logic            w_done_edge;
  logic            w_capture;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_drop;
  logic [ACC_W:0]  w_sum;

  assign w_done_edge = mlu_ready & ~r_rdy_q;
  assign w_capture   = (r_state == COLL_WAIT) & w_done_edge;
  assign w_pop       = ~w_empty & out_ready;
  assign w_push_ok   = w_capture & (~w_full | w_pop);
  assign w_drop      = w_capture & w_full & ~w_pop;
  assign w_sum       = {1'b0, r_acc} + (ACC_W+1)'(mlu_result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLL_IDLE;
      r_start   <= 1'b0;
      r_rdy_q   <= 1'b1;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_rdy_q <= mlu_ready;
      r_start <= 1'b0;
      if (clr) r_timeout <= 1'b0;
      case (r_state)
        COLL_IDLE: begin
          if (go) begin
            r_state <= COLL_ARM;
            r_start <= 1'b1;
          end
        end
        COLL_ARM: begin
          r_state <= COLL_WAIT;
          r_wdog  <= '0;
        end
        COLL_WAIT: begin
          // A done edge on the last watchdog cycle still counts as a completion.
          if (w_done_edge) begin
            r_state <= COLL_IDLE;
          end else if (r_wdog == WD_W'(TIMEOUT-1)) begin
            r_state <= COLL_IDLE;
            if (!clr) r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= COLL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
      if (w_drop)    r_overflow <= 1'b1;
    end
  end

  mlu_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_din   (mlu_result),
    .o_dout  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign out_valid = ~w_empty;
  assign mlu_start = r_start;
  assign acc       = r_acc;
  assign overflow  = r_overflow;
  assign timeout   = r_timeout;

endmodule
